// File: rtl/mux_pkg.sv
// mux_pkg: shared select-mode type and width helper for the registered mux family
package mux_pkg;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/muxn_comb.sv
// muxn_comb: combinational one-hot N:1 data selector built as an AND-OR tree
module muxn_comb #(
  parameter int WIDTH = 1,
  parameter int N     = 2
) (
  input  logic [N*WIDTH-1:0] data,
  input  logic [N-1:0]       onehot,
  output logic [WIDTH-1:0]   y
);
  // OR together every channel masked by its grant bit; a zero grant yields zero
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) y = y | (data[i*WIDTH +: WIDTH] & {WIDTH{onehot[i]}});
  end
endmodule

// File: rtl/muxn_reg.sv
// muxn_reg: N-channel registered mux with valid/ready flow control and fixed or round-robin select
module muxn_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N     = 2,
  localparam int SELW = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  mode_e              mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [N-1:0]    g;
  logic [SELW-1:0] rr_ptr, g_idx, rr_nxt;
  logic [WIDTH-1:0] sel_data;
  logic            free, accept, found;
  int              idx;
  assign free   = ~out_valid | out_ready;
  assign in_ready = g & {N{free & ~rst}};
  assign accept = |in_ready;
  // Grant: fixed select (out-of-range sel grants nothing) or first valid channel from rr_ptr, wrapping at N
  always_comb begin
    g     = '0;
    found = 1'b0;
    idx   = 0;
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < N; i++) g[i] = (sel == SELW'(i)) & in_valid[i];
    end else begin
      for (int j = 0; j < N; j++) begin
        idx = int'(rr_ptr) + j;
        idx = (idx >= N) ? idx - N : idx;
        if (!found && in_valid[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
  // Encode the one-hot grant and the pointer value that follows it
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++) if (g[i]) g_idx = SELW'(i);
    rr_nxt = (int'(g_idx) == N - 1) ? '0 : g_idx + 1'b1;
  end
  muxn_comb #(.WIDTH(WIDTH), .N(N)) u_sel (
    .data   (in_data),
    .onehot (g),
    .y      (sel_data)
  );
  // Output stage: load on accept, drain when consumer takes the word, otherwise hold; advance rr_ptr on RR accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= g_idx;
      if (mode == MODE_RR) rr_ptr <= rr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_muxn_reg.sv
// tb_muxn_reg: directed checks of a 4-channel and a 3-channel registered mux
module tb_muxn_reg;
  import mux_pkg::*;
  logic clk = 1'b0;
  logic rst;
  mode_e mode_a, mode_b;
  logic [1:0] sel_a, sel_b;
  logic [31:0] data_a;
  logic [23:0] data_b;
  logic [3:0] valid_a, ready_a;
  logic [2:0] valid_b, ready_b;
  logic [7:0] odata_a, odata_b;
  logic [1:0] och_a, och_b;
  logic ovalid_a, ovalid_b, oready_a, oready_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  muxn_reg #(.WIDTH(8), .N(4)) dut_a (
    .clk(clk), .rst(rst), .mode(mode_a), .sel(sel_a), .in_data(data_a), .in_valid(valid_a),
    .in_ready(ready_a), .out_data(odata_a), .out_ch(och_a), .out_valid(ovalid_a), .out_ready(oready_a)
  );
  muxn_reg #(.WIDTH(8), .N(3)) dut_b (
    .clk(clk), .rst(rst), .mode(mode_b), .sel(sel_b), .in_data(data_b), .in_valid(valid_b),
    .in_ready(ready_b), .out_data(odata_b), .out_ch(och_b), .out_valid(ovalid_b), .out_ready(oready_b)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic out_b(input string tag, input logic [1:0] ch, input logic [7:0] d);
    step();
    check({tag, "_valid"}, 32'(ovalid_b), 32'd1);
    check({tag, "_ch"}, 32'(och_b), 32'(ch));
    check({tag, "_data"}, 32'(odata_b), 32'(d));
  endtask
  initial begin
    rst = 1'b1;
    mode_a = MODE_FIXED; sel_a = 2'd2; data_a = {8'h44, 8'hA5, 8'h22, 8'h11}; valid_a = 4'b1111; oready_a = 1'b1;
    mode_b = MODE_RR;    sel_b = 2'd0; data_b = {8'hC2, 8'hB1, 8'hA0};        valid_b = 3'b111;  oready_b = 1'b1;
    #1;
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    step();
    step();
    check("rst_ready_a2", 32'(ready_a), 32'd0);
    check("rst_valid_a", 32'(ovalid_a), 32'd0);
    check("rst_data_a", 32'(odata_a), 32'd0);
    check("rst_ch_a", 32'(och_a), 32'd0);
    check("rst_valid_b", 32'(ovalid_b), 32'd0);
    check("rst_ch_b", 32'(och_b), 32'd0);
    valid_b = 3'b000;
    rst = 1'b0;
    #1;
    check("fix_ready", 32'(ready_a), 32'b0100);
    step();
    check("fix_valid", 32'(ovalid_a), 32'd1);
    check("fix_data", 32'(odata_a), 32'hA5);
    check("fix_ch", 32'(och_a), 32'd2);
    data_a[23:16] = 8'h3C;
    step();
    check("bp_load", 32'(odata_a), 32'h3C);
    data_a[23:16] = 8'h77;
    oready_a = 1'b0;
    #1;
    check("bp_ready0", 32'(ready_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_data", 32'(odata_a), 32'h3C);
      check("bp_hold_ch", 32'(och_a), 32'd2);
      check("bp_hold_valid", 32'(ovalid_a), 32'd1);
      check("bp_hold_ready", 32'(ready_a), 32'd0);
    end
    oready_a = 1'b1;
    #1;
    check("bp_release_ready", 32'(ready_a), 32'b0100);
    step();
    check("bp_next_data", 32'(odata_a), 32'h77);
    check("bp_next_valid", 32'(ovalid_a), 32'd1);
    valid_a = 4'b0000;
    step();
    check("drain_a", 32'(ovalid_a), 32'd0);
    valid_b = 3'b111;
    out_b("rr0", 2'd0, 8'hA0);
    out_b("rr1", 2'd1, 8'hB1);
    out_b("rr2", 2'd2, 8'hC2);
    out_b("rr3", 2'd0, 8'hA0);
    out_b("rr4", 2'd1, 8'hB1);
    out_b("rr5", 2'd2, 8'hC2);
    out_b("rr6", 2'd0, 8'hA0);
    valid_b = 3'b001;
    #1;
    check("skip_ready", 32'(ready_b), 32'b001);
    out_b("skip", 2'd0, 8'hA0);
    valid_b = 3'b111;
    out_b("skip_ptr", 2'd1, 8'hB1);
    mode_b = MODE_FIXED;
    sel_b = 2'd3;
    #1;
    check("oor_ready", 32'(ready_b), 32'd0);
    step();
    check("oor_drain", 32'(ovalid_b), 32'd0);
    sel_b = 2'd0;
    out_b("fix_b", 2'd0, 8'hA0);
    mode_b = MODE_RR;
    out_b("ptr_kept", 2'd2, 8'hC2);
    oready_b = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(ready_b), 32'd0);
    step();
    check("midrst_valid", 32'(ovalid_b), 32'd0);
    check("midrst_data", 32'(odata_b), 32'd0);
    rst = 1'b0;
    oready_b = 1'b1;
    out_b("post_rst", 2'd0, 8'hA0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
